// File: rtl/mac_switch_np.sv
// mac_switch_np: N-port learning switch core with an aging, register-based MAC table.
// Learns each frame's source MAC, looks up its destination and replays header + payload to the egress mask.
module mac_switch_np #(
   parameter int NUM_PORTS   = 4,
   parameter int PORT_W      = 2,
   parameter int TABLE_DEPTH = 16,
   parameter int AGE_MAX     = 15
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          hdr_valid,
   output logic                          hdr_ready,
   input  logic                          hdr_frame_ok,
   input  logic [PORT_W-1:0]             hdr_port,
   input  logic [47:0]                   hdr_dst,
   input  logic [47:0]                   hdr_src,
   input  logic [15:0]                   hdr_type,
   input  logic [7:0]                    pl_data,
   input  logic                          pl_valid,
   input  logic                          pl_last,
   output logic                          pl_ready,
   input  logic [NUM_PORTS-1:0]          port_afull,
   output logic [7:0]                    tx_data,
   output logic                          tx_last,
   output logic [NUM_PORTS-1:0]          tx_wren,
   input  logic                          age_tick,
   input  logic                          flush,
   output logic [$clog2(TABLE_DEPTH):0]  table_count
);

   localparam int IDX_W = $clog2(TABLE_DEPTH);
   localparam int CNT_W = IDX_W + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_LEARN  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_TX_HDR = 3'd4;
   localparam logic [2:0] S_TX_PAY = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   logic [2:0]             state_q, state_d;
   logic [3:0]             hcnt_q, hcnt_d;
   logic                   ok_q;
   logic [PORT_W-1:0]      in_port_q;
   logic [47:0]            dst_q, src_q;
   logic [15:0]            type_q;
   logic                   src_hit_q, dst_hit_q;
   logic [IDX_W-1:0]       src_idx_q;
   logic [PORT_W-1:0]      dst_port_q;
   logic [NUM_PORTS-1:0]   mask_q;
   logic                   hdr_ready_q, hdr_ready_d, pop_dly_q;
   logic                   pl_ready_q, pl_ready_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic                   tx_last_q, tx_last_d;
   logic [NUM_PORTS-1:0]   tx_wren_q, tx_wren_d;

   logic [TABLE_DEPTH-1:0] valid_q, valid_d;
   logic [47:0]            mac_q  [TABLE_DEPTH];
   logic [47:0]            mac_d  [TABLE_DEPTH];
   logic [PORT_W-1:0]      port_q [TABLE_DEPTH];
   logic [PORT_W-1:0]      port_d [TABLE_DEPTH];
   logic [7:0]             age_q  [TABLE_DEPTH];
   logic [7:0]             age_d  [TABLE_DEPTH];
   logic [IDX_W-1:0]       vp_q, vp_d;
   logic [CNT_W-1:0]       count_q, count_s;

   logic                   src_hit_s, dst_hit_s, free_found_s, learn_s, accept_s;
   logic [IDX_W-1:0]       src_idx_s, dst_idx_s, free_idx_s, widx_s;
   logic [NUM_PORTS-1:0]   mask_s;
   logic [111:0]           hdr_shift_s;

   // The popped header stays visible until the pop lands, so IDLE ignores it for two cycles.
   assign accept_s = (state_q == S_IDLE) && hdr_valid && !hdr_ready_q && !pop_dly_q;
   assign learn_s  = (state_q == S_LEARN) && ok_q && !src_q[40] && !flush;
   assign widx_s   = src_hit_q ? src_idx_q : (free_found_s ? free_idx_s : vp_q);

   // Parallel match of latched src/dst against valid entries; descending scan keeps the lowest index
   always_comb begin
      src_hit_s    = 1'b0;
      src_idx_s    = '0;
      dst_hit_s    = 1'b0;
      dst_idx_s    = '0;
      free_found_s = 1'b0;
      free_idx_s   = '0;
      for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
         src_hit_s    = (valid_q[i] && (mac_q[i] == src_q)) ? 1'b1 : src_hit_s;
         src_idx_s    = (valid_q[i] && (mac_q[i] == src_q)) ? IDX_W'(i) : src_idx_s;
         dst_hit_s    = (valid_q[i] && (mac_q[i] == dst_q)) ? 1'b1 : dst_hit_s;
         dst_idx_s    = (valid_q[i] && (mac_q[i] == dst_q)) ? IDX_W'(i) : dst_idx_s;
         free_found_s = !valid_q[i] ? 1'b1 : free_found_s;
         free_idx_s   = !valid_q[i] ? IDX_W'(i) : free_idx_s;
      end
   end

   // Forwarding mask from the pre-learn lookup; the ingress port is never a target
   always_comb begin
      mask_s = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (!ok_q) begin
            mask_s[p] = 1'b0;
         end else if (dst_q[40] || !dst_hit_q) begin
            mask_s[p] = (PORT_W'(p) != in_port_q);
         end else begin
            mask_s[p] = (PORT_W'(p) == dst_port_q) && (dst_port_q != in_port_q);
         end
      end
   end

   // Table next state: aging, then learn write (wins over aging), then flush (wins over everything)
   always_comb begin
      valid_d = valid_q;
      vp_d    = vp_q;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
         mac_d[i]  = mac_q[i];
         port_d[i] = port_q[i];
         age_d[i]  = age_q[i];
         if (age_tick && valid_q[i]) begin
            age_d[i]   = (age_q[i] == 8'hFF) ? 8'hFF : age_q[i] + 8'd1;
            valid_d[i] = (age_d[i] < 8'(AGE_MAX));
         end else begin
            age_d[i] = age_q[i];
         end
         if (learn_s && (widx_s == IDX_W'(i))) begin
            valid_d[i] = 1'b1;
            mac_d[i]   = src_q;
            port_d[i]  = in_port_q;
            age_d[i]   = 8'd0;
         end else begin
            mac_d[i] = mac_d[i];
         end
      end
      if (learn_s && !src_hit_q && !free_found_s) begin
         vp_d = vp_q + IDX_W'(1);
      end else begin
         vp_d = vp_q;
      end
      if (flush) begin
         valid_d = '0;
         vp_d    = '0;
      end else begin
         valid_d = valid_d;
      end
   end

   // Population count of valid entries, registered one cycle later
   always_comb begin
      count_s = '0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
         count_s = count_s + CNT_W'(valid_q[i]);
      end
   end

   assign hdr_shift_s = {dst_q, src_q, type_q} << {hcnt_q, 3'b000};

   // Frame sequencing and registered egress outputs
   always_comb begin
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      tx_data_d   = 8'd0;
      tx_last_d   = 1'b0;
      tx_wren_d   = '0;
      hdr_ready_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_s) state_d = S_LOOKUP;
            else          state_d = S_IDLE;
         end
         S_LOOKUP: state_d = S_LEARN;
         S_LEARN:  state_d = S_WAIT;
         S_WAIT: begin
            hcnt_d = 4'd0;
            if ((mask_q & port_afull) != '0) state_d = S_WAIT;
            else if (mask_q == '0)           state_d = S_TX_PAY;
            else                             state_d = S_TX_HDR;
         end
         S_TX_HDR: begin
            tx_data_d = hdr_shift_s[111:104];
            tx_wren_d = mask_q;
            if (hcnt_q == 4'd13) begin
               state_d = S_TX_PAY;
            end else begin
               hcnt_d = hcnt_q + 4'd1;
            end
         end
         S_TX_PAY: begin
            if (pl_valid) begin
               tx_data_d = pl_data;
               tx_wren_d = mask_q;
               tx_last_d = pl_last;
               state_d   = pl_last ? S_DONE : S_TX_PAY;
            end else begin
               state_d = S_TX_PAY;
            end
         end
         S_DONE: begin
            hdr_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      pl_ready_d = (state_d == S_TX_PAY);
   end

   // FSM, frame context and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         hcnt_q      <= 4'd0;
         ok_q        <= 1'b0;
         in_port_q   <= '0;
         dst_q       <= 48'd0;
         src_q       <= 48'd0;
         type_q      <= 16'd0;
         src_hit_q   <= 1'b0;
         dst_hit_q   <= 1'b0;
         src_idx_q   <= '0;
         dst_port_q  <= '0;
         mask_q      <= '0;
         hdr_ready_q <= 1'b0;
         pop_dly_q   <= 1'b0;
         pl_ready_q  <= 1'b0;
         tx_data_q   <= 8'd0;
         tx_last_q   <= 1'b0;
         tx_wren_q   <= '0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         hdr_ready_q <= hdr_ready_d;
         pop_dly_q   <= hdr_ready_q;
         pl_ready_q  <= pl_ready_d;
         tx_data_q   <= tx_data_d;
         tx_last_q   <= tx_last_d;
         tx_wren_q   <= tx_wren_d;
         if (accept_s) begin
            ok_q      <= hdr_frame_ok;
            in_port_q <= hdr_port;
            dst_q     <= hdr_dst;
            src_q     <= hdr_src;
            type_q    <= hdr_type;
         end
         if (state_q == S_LOOKUP) begin
            src_hit_q  <= src_hit_s;
            src_idx_q  <= src_idx_s;
            dst_hit_q  <= dst_hit_s;
            dst_port_q <= port_q[dst_idx_s];
         end
         if (state_q == S_LEARN) begin
            mask_q <= mask_s;
         end
      end
   end

   // MAC table storage, victim pointer and entry count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         vp_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < TABLE_DEPTH; i++) begin
            mac_q[i]  <= 48'd0;
            port_q[i] <= '0;
            age_q[i]  <= 8'd0;
         end
      end else begin
         valid_q <= valid_d;
         vp_q    <= vp_d;
         count_q <= count_s;
         for (int i = 0; i < TABLE_DEPTH; i++) begin
            mac_q[i]  <= mac_d[i];
            port_q[i] <= port_d[i];
            age_q[i]  <= age_d[i];
         end
      end
   end

   assign hdr_ready   = hdr_ready_q;
   assign pl_ready    = pl_ready_q;
   assign tx_data     = tx_data_q;
   assign tx_last     = tx_last_q;
   assign tx_wren     = tx_wren_q;
   assign table_count = count_q;

endmodule

// File: tb/tb_mac_switch_np.sv
// tb_mac_switch_np: directed and randomized frames checked against a behavioural switch model.
// The model keeps the MAC table as plain arrays and predicts the egress byte stream per frame.
module tb_mac_switch_np;

   localparam int NP = 4;
   localparam int PW = 2;
   localparam int TD = 4;
   localparam int AM = 3;
   localparam int CW = $clog2(TD) + 1;

   logic          clk = 1'b0;
   logic          rst_n, hdr_valid, hdr_ready, hdr_frame_ok;
   logic [PW-1:0] hdr_port;
   logic [47:0]   hdr_dst, hdr_src;
   logic [15:0]   hdr_type;
   logic [7:0]    pl_data, tx_data;
   logic          pl_valid, pl_last, pl_ready, tx_last, age_tick, flush;
   logic [NP-1:0] port_afull, tx_wren;
   logic [CW-1:0] table_count;

   int n_cmp = 0;
   int n_err = 0;

   bit          m_valid [TD];
   logic [47:0] m_mac   [TD];
   int          m_port  [TD];
   int          m_age   [TD];
   int          m_vp;

   always #5 clk = ~clk;

   mac_switch_np #(.NUM_PORTS(NP), .PORT_W(PW), .TABLE_DEPTH(TD), .AGE_MAX(AM)) dut (
      .clk(clk), .rst_n(rst_n), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
      .hdr_frame_ok(hdr_frame_ok), .hdr_port(hdr_port), .hdr_dst(hdr_dst), .hdr_src(hdr_src),
      .hdr_type(hdr_type), .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
      .pl_ready(pl_ready), .port_afull(port_afull), .tx_data(tx_data), .tx_last(tx_last),
      .tx_wren(tx_wren), .age_tick(age_tick), .flush(flush), .table_count(table_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < TD; i++) m_valid[i] = 1'b0;
      m_vp = 0;
   endfunction

   function automatic int m_find(input logic [47:0] mac);
      for (int i = 0; i < TD; i++) if (m_valid[i] && m_mac[i] == mac) return i;
      return -1;
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < TD; i++) if (m_valid[i]) c++;
      return c;
   endfunction

   function automatic void m_tick();
      for (int i = 0; i < TD; i++) begin
         if (m_valid[i]) begin
            m_age[i] = (m_age[i] < 255) ? m_age[i] + 1 : 255;
            if (m_age[i] >= AM) m_valid[i] = 1'b0;
         end
      end
   endfunction

   function automatic logic [NP-1:0] m_mask(input int port, input logic [47:0] dst, input bit ok);
      int d;
      logic [NP-1:0] all_p;
      all_p = '1;
      d = m_find(dst);
      if (!ok) return '0;
      if (dst[40] || d < 0) return all_p & ~(NP'(1) << port);
      if (m_port[d] == port) return '0;
      return NP'(1) << m_port[d];
   endfunction

   // One frame's table effect: hit/free decided on the pre-tick table, learn write beats aging
   function automatic void m_learn(input int port, input logic [47:0] src, input bit ok,
                                   input bit tick, input bit fl);
      int hit, free, w;
      hit  = m_find(src);
      free = -1;
      for (int i = TD - 1; i >= 0; i--) if (!m_valid[i]) free = i;
      if (fl) begin
         m_reset();
         return;
      end
      if (tick) m_tick();
      if (ok && !src[40]) begin
         if (hit >= 0) w = hit;
         else if (free >= 0) w = free;
         else begin
            w = m_vp;
            m_vp = (m_vp + 1) % TD;
         end
         m_valid[w] = 1'b1;
         m_mac[w]   = src;
         m_port[w]  = port;
         m_age[w]   = 0;
      end
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic tick_idle();
      age_tick = 1'b1;
      idle(1);
      age_tick = 1'b0;
      m_tick();
      idle(1);
      check_eq("count_after_tick", table_count, m_count());
   endtask

   task automatic flush_idle();
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      m_reset();
      idle(1);
      check_eq("count_after_flush", table_count, m_count());
   endtask

   task automatic run_frame(input int port, input logic [47:0] dst, input logic [47:0] src,
                            input bit ok, input int len, input logic [NP-1:0] afull,
                            input int hold, input bit tick_l, input bit flush_l);
      logic [7:0]    pay [$];
      logic [NP+8:0] exp_q [$];
      logic [NP+8:0] obs_q [$];
      logic [111:0]  hv;
      logic [15:0]   typ;
      logic [NP-1:0] mask;
      int            cyc, pidx, first_cyc, acc_cyc, hr_cyc, hr_cnt, exp_first;
      bit            done;
      typ = 16'($urandom);
      hv  = {dst, src, typ};
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      mask = m_mask(port, dst, ok);
      m_learn(port, src, ok, tick_l, flush_l);
      if (mask != '0) begin
         for (int k = 0; k < 14; k++) exp_q.push_back({mask, 1'b0, hv[111 - 8*k -: 8]});
         for (int i = 0; i < len; i++) exp_q.push_back({mask, (i == len - 1), pay[i]});
      end
      exp_first = (((mask & afull) != '0) && (hold + 2 > 5)) ? hold + 2 : 5;
      hdr_port = PW'(port); hdr_dst = dst; hdr_src = src; hdr_type = typ;
      hdr_frame_ok = ok; hdr_valid = 1'b1; port_afull = afull;
      cyc = 0; pidx = 0; first_cyc = -1; acc_cyc = -1; hr_cyc = -1; hr_cnt = 0; done = 1'b0;
      while (!done && cyc < 400) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         age_tick = 1'b0;
         flush    = 1'b0;
         if (tx_wren != '0) begin
            obs_q.push_back({tx_wren, tx_last, tx_data});
            if (first_cyc < 0) first_cyc = cyc;
         end
         if (hdr_ready) begin
            hr_cnt++;
            if (hr_cyc < 0) hr_cyc = cyc;
            hdr_valid = 1'b0;
         end
         if (cyc == acc_cyc) check_eq("pl_ready_drop", pl_ready, 1'b0);
         if (hr_cyc >= 0 && cyc >= hr_cyc + 3) done = 1'b1;
         if (cyc == hold) port_afull = '0;
         if (cyc == 2 && tick_l) age_tick = 1'b1;
         if (cyc == 2 && flush_l) flush = 1'b1;
         pl_valid = 1'b0; pl_last = 1'b0; pl_data = 8'd0;
         if (pl_ready && pidx < len && $urandom_range(0, 3) != 0) begin
            pl_valid = 1'b1;
            pl_data  = pay[pidx];
            pl_last  = (pidx == len - 1);
            if (pidx == len - 1) acc_cyc = cyc + 1;
            pidx++;
         end
      end
      hdr_valid = 1'b0; port_afull = '0; pl_valid = 1'b0; pl_last = 1'b0;
      check_eq("frame_done", done, 1'b1);
      check_eq("beat_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check_eq($sformatf("beat%0d", i), obs_q[i], exp_q[i]);
      check_eq("hdr_ready_pulses", hr_cnt, 1);
      check_eq("hdr_ready_time", hr_cyc, acc_cyc + 1);
      if (mask != '0) check_eq("first_byte_cycle", first_cyc, exp_first);
      check_eq("table_count", table_count, m_count());
   endtask

   task automatic reset_mid_frame();
      logic [NP-1:0] exp_mask;
      exp_mask = m_mask(2, 48'hFFFF_FFFF_FFFF, 1'b1);
      hdr_port = 2'd2; hdr_dst = 48'hFFFF_FFFF_FFFF; hdr_src = 48'h0200_0000_0077;
      hdr_frame_ok = 1'b1; hdr_valid = 1'b1;
      idle(8);
      check_eq("midframe_wren", tx_wren, exp_mask);
      rst_n = 1'b0;
      idle(1);
      check_eq("rst_hdr_ready", hdr_ready, 1'b0);
      check_eq("rst_pl_ready", pl_ready, 1'b0);
      check_eq("rst_tx_wren", tx_wren, '0);
      check_eq("rst_tx_data", tx_data, 8'd0);
      rst_n = 1'b1;
      hdr_valid = 1'b0;
      m_reset();
      idle(2);
      check_eq("rst_table_count", table_count, m_count());
   endtask

   function automatic logic [47:0] pool_mac(input int k);
      if (k == 6) return 48'h0100_0000_0006;
      return 48'h0200_0000_0000 | 48'(k);
   endfunction

   localparam logic [47:0] MAC_A = 48'h0200_0000_000A;
   localparam logic [47:0] MAC_B = 48'h0200_0000_000B;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   initial begin
      rst_n = 1'b0; hdr_valid = 1'b0; hdr_frame_ok = 1'b0; hdr_port = '0;
      hdr_dst = 48'd0; hdr_src = 48'd0; hdr_type = 16'd0; pl_data = 8'd0;
      pl_valid = 1'b0; pl_last = 1'b0; port_afull = '0; age_tick = 1'b0; flush = 1'b0;
      m_reset();
      idle(3);
      check_eq("reset_hdr_ready", hdr_ready, 1'b0);
      check_eq("reset_pl_ready", pl_ready, 1'b0);
      check_eq("reset_tx_data", tx_data, 8'd0);
      check_eq("reset_tx_last", tx_last, 1'b0);
      check_eq("reset_tx_wren", tx_wren, '0);
      check_eq("reset_table_count", table_count, '0);
      rst_n = 1'b1;
      idle(2);

      run_frame(1, MAC_B, MAC_A, 1'b1, 4, '0, 0, 1'b0, 1'b0);                        // unknown unicast
      run_frame(3, MAC_A, 48'h0200_0000_000C, 1'b1, 3, '0, 0, 1'b0, 1'b0);           // learned unicast
      run_frame(1, MAC_A, 48'h0200_0000_000D, 1'b1, 2, '0, 0, 1'b0, 1'b0);           // same-port drop
      run_frame(3, MAC_A, 48'h0200_0000_000C, 1'b1, 5, 4'b0010, 9, 1'b0, 1'b0);      // backpressure
      run_frame(2, MAC_A, 48'h0200_0000_000E, 1'b0, 3, '0, 0, 1'b0, 1'b0);           // bad frame
      run_frame(0, BCAST, 48'h0200_0000_000F, 1'b1, 2, '0, 0, 1'b0, 1'b0);           // broadcast
      run_frame(2, BCAST, 48'h0200_0000_0010, 1'b1, 2, '0, 0, 1'b0, 1'b0);           // evicts entry 0
      run_frame(2, MAC_A, 48'h0200_0000_0010, 1'b1, 2, '0, 0, 1'b0, 1'b0);           // evicted dst floods
      run_frame(0, MAC_B, 48'h0200_0000_0011, 1'b1, 2, '0, 0, 1'b0, 1'b1);           // flush during learn

      run_frame(1, BCAST, MAC_A, 1'b1, 2, '0, 0, 1'b0, 1'b0);
      tick_idle();
      tick_idle();
      tick_idle();
      run_frame(2, MAC_A, MAC_B, 1'b1, 3, '0, 0, 1'b0, 1'b0);                        // aged dst floods
      tick_idle();
      run_frame(1, MAC_A, MAC_B, 1'b1, 2, '0, 0, 1'b1, 1'b0);                        // learn beats tick

      for (int f = 0; f < 40; f++) begin
         int s, d, pt, hold;
         logic [NP-1:0] af;
         s    = $urandom_range(0, 6);
         d    = $urandom_range(0, 7);
         pt   = $urandom_range(0, NP - 1);
         af   = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
         hold = $urandom_range(2, 12);
         run_frame(pt, (d == 7) ? BCAST : pool_mac(d), pool_mac(s), ($urandom_range(0, 9) != 0),
                   $urandom_range(1, 6), af, hold, ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 3) == 0) tick_idle();
         if ($urandom_range(0, 19) == 0) flush_idle();
      end

      reset_mid_frame();
      run_frame(0, BCAST, MAC_A, 1'b1, 3, '0, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
